// File: rtl/ccff_bitstream_loader_if.sv
// Bundle of the loader's control, byte-stream, chain and readback signals.
// The loader takes the slave modport; the bench or host side takes the master modport.
interface ccff_bitstream_loader_if;
   logic       start;
   logic       busy;
   logic       done;
   logic [7:0] din_data;
   logic       din_valid;
   logic       din_ready;
   logic       ccff_head;
   logic       ccff_shift_en;
   logic       ccff_tail;
   logic [7:0] rb_data;
   logic       rb_valid;

   modport master (
      output start, din_data, din_valid, ccff_tail,
      input  busy, done, din_ready, ccff_head, ccff_shift_en, rb_data, rb_valid
   );

   modport slave (
      input  start, din_data, din_valid, ccff_tail,
      output busy, done, din_ready, ccff_head, ccff_shift_en, rb_data, rb_valid
   );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Streams a byte-wide bitstream MSB-first into a configuration flip-flop chain of
// CHAIN_LEN bits, collecting the bits leaving the chain tail into readback bytes.
module ccff_bitstream_loader #(
   parameter int unsigned CHAIN_LEN = 56
) (
   input  logic                    prog_clk,
   input  logic                    pReset,
   ccff_bitstream_loader_if.slave  bus
);
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned BCNT_W = 4;
   localparam int unsigned RBC_W  = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        state_q,   state_d;
   logic [CNT_W-1:0]  rem_q,     rem_d;
   logic [BCNT_W-1:0] bcnt_q,    bcnt_d;
   logic [BYTE_W-1:0] sreg_q,    sreg_d;
   logic [BYTE_W-1:0] rb_sreg_q, rb_sreg_d;
   logic [RBC_W-1:0]  rb_cnt_q,  rb_cnt_d;
   logic [BYTE_W-1:0] rb_data_q, rb_data_d;
   logic              rb_valid_q, rb_valid_d;
   logic              busy_q, done_q, din_ready_q, head_q, shift_en_q;

   // Next-state, datapath and readback assembly
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      bcnt_d     = bcnt_q;
      sreg_d     = sreg_q;
      rb_sreg_d  = rb_sreg_q;
      rb_cnt_d   = rb_cnt_q;
      rb_data_d  = rb_data_q;
      rb_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_FETCH;
               rem_d   = CNT_W'(CHAIN_LEN);
            end
         end
         ST_FETCH: begin
            if (bus.din_valid) begin
               sreg_d  = bus.din_data;
               bcnt_d  = (rem_q >= CNT_W'(BYTE_W)) ? BCNT_W'(BYTE_W) : BCNT_W'(rem_q);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sreg_d = {sreg_q[BYTE_W-2:0], 1'b0};
            bcnt_d = bcnt_q - BCNT_W'(1);
            rem_d  = rem_q - CNT_W'(1);
            if (bcnt_q == BCNT_W'(1)) begin
               state_d = (rem_q == CNT_W'(1)) ? ST_DONE : ST_FETCH;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Tail bits fill the readback byte from the MSB down, so a short final byte is left-aligned
      if (shift_en_q) begin
         rb_sreg_d[RBC_W'(BYTE_W - 1) - rb_cnt_q] = bus.ccff_tail;
         rb_cnt_d = rb_cnt_q + RBC_W'(1);
         if ((rb_cnt_q == RBC_W'(BYTE_W - 1)) || (rem_q == CNT_W'(1))) begin
            rb_data_d  = rb_sreg_d;
            rb_valid_d = 1'b1;
            rb_sreg_d  = '0;
            rb_cnt_d   = '0;
         end
      end
   end

   // State and registered outputs, decoded from the next state
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         bcnt_q      <= '0;
         sreg_q      <= '0;
         rb_sreg_q   <= '0;
         rb_cnt_q    <= '0;
         rb_data_q   <= '0;
         rb_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         din_ready_q <= 1'b0;
         head_q      <= 1'b0;
         shift_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         bcnt_q      <= bcnt_d;
         sreg_q      <= sreg_d;
         rb_sreg_q   <= rb_sreg_d;
         rb_cnt_q    <= rb_cnt_d;
         rb_data_q   <= rb_data_d;
         rb_valid_q  <= rb_valid_d;
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
         din_ready_q <= (state_d == ST_FETCH);
         head_q      <= (state_d == ST_SHIFT) && sreg_d[BYTE_W-1];
         shift_en_q  <= (state_d == ST_SHIFT);
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.din_ready     = din_ready_q;
   assign bus.ccff_head     = head_q;
   assign bus.ccff_shift_en = shift_en_q;
   assign bus.rb_data       = rb_data_q;
   assign bus.rb_valid      = rb_valid_q;
endmodule

// File: doc/ccff_bitstream_loader.md
CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

Interface
REQ-001 Parameter: CHAIN_LEN, default 56, total configuration-chain length in bits; legal range 1..65535.
REQ-002 prog_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 pReset  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  load request; sampled in IDLE only.
REQ-005 busy  out  1  high in every state except IDLE.
REQ-006 done  out  1  one-cycle pulse when the full chain has been loaded.
REQ-007 din_data  in  8  bitstream byte, MSB shifted first.
REQ-008 din_valid  in  1  din_data valid.
REQ-009 din_ready  out  1  loader accepts din_data this cycle.
REQ-010 ccff_head  out  1  serial data into the configuration chain head.
REQ-011 ccff_shift_en  out  1  chain clock enable; the chain shifts exactly on edges where this is high.
REQ-012 ccff_tail  in  1  serial data from the configuration chain tail.
REQ-013 rb_data  out  8  readback byte of bits leaving the chain, MSB first.
REQ-014 rb_valid  out  1  one-cycle pulse qualifying rb_data; no backpressure.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, SHIFT and DONE; a 16-bit remaining-bit counter SHALL be loaded with CHAIN_LEN on leaving IDLE.
REQ-016 IDLE->FETCH SHALL occur on the edge where start=1; start in any other state SHALL be ignored.
REQ-017 In FETCH, din_ready=1; a transfer occurs when din_valid=1 and din_ready=1, loading din_data into an 8-bit shift register and a bit count of min(8, remaining); the next state is SHIFT.
REQ-018 FETCH with din_valid=0 SHALL hold state, with ccff_shift_en=0; a stall is not an error.
REQ-019 din_ready SHALL be 0 in IDLE, SHIFT and DONE.
REQ-020 In SHIFT, ccff_shift_en=1 every cycle and ccff_head SHALL equal shift-register bit 7; the register shifts left, zero-filled; the bit count and remaining counter each decrement by 1 per cycle.
REQ-021 When the byte bit count reaches 0, the FSM SHALL go to DONE if remaining=0, otherwise to FETCH.
REQ-022 Final partial byte: only its (CHAIN_LEN mod 8) MSBs are shifted; its low bits SHALL be discarded.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 ccff_head SHALL be 0 whenever ccff_shift_en=0.
REQ-025 On every edge with ccff_shift_en=1, ccff_tail SHALL be captured into the readback register, MSB first.
REQ-026 After 8 captured bits, or after the final bit of the load, rb_data SHALL update and rb_valid SHALL pulse in the following cycle.
REQ-027 A final partial readback byte SHALL be left-aligned with zero low bits.
REQ-028 The final rb_valid SHALL coincide with done.
REQ-029 Exactly CHAIN_LEN ccff_shift_en cycles SHALL occur per load.
REQ-030 Throughput with din_valid held high is 1 FETCH cycle plus up to 8 SHIFT cycles per byte.

Reset
REQ-031 When pReset=1 on an edge: state=IDLE, all counters and shift registers clear, and busy, done, din_ready, ccff_head, ccff_shift_en, rb_valid=0 and rb_data=0x00.
REQ-032 Reset mid-load SHALL abort immediately with no further shift enables; the partial readback byte SHALL be discarded with no rb_valid, and the chain contents are left undefined.
REQ-033 pReset SHALL take priority over start arriving in the same cycle.

Verification
REQ-034 Scenario: CHAIN_LEN=56, 56-bit chain model preloaded with all ones, start at cycle 0, din_valid held with bytes 0x01..0x07 -> FETCH at cycles 1,10,...,55; shift_en high for 56 cycles; done at cycle 64; seven rb bytes all 0xFF; chain then holds 0x01..0x07.
REQ-035 Scenario: second load of 0xFF x7 on the same chain -> rb bytes are 0x01..0x07 in order.
REQ-036 Scenario: CHAIN_LEN=5, byte 0xAB -> ccff_head sequence 1,0,1,0,1 on cycles 2-6; done at cycle 7; one rb byte, left-aligned, low 3 bits 0.
REQ-037 Scenario: din_valid low for 3 cycles in the second FETCH -> FSM holds FETCH, no shift_en, head=0; done is delayed by exactly 3 cycles.
REQ-038 Scenario: pReset pulsed at cycle 20 of a load -> next cycle busy=0 and shift_en=0; a fresh start then completes normally with exactly 56 shifts.
REQ-039 Scenario: start pulsed while busy -> ignored; the shift_en count stays exactly CHAIN_LEN and only one done pulse occurs.
